// File: rtl/score_packer.sv
// score_packer: collects a stream of signed scores, one per accepted cycle,
// into a packed K x N-bit frame for the downstream argmax stage. The frame
// is held stable with valid_o high until ack_i, then the packer refills.
//
// Ports:
//   clk_i, rst_i    clock (rising edge), async active-high reset
//   data_i/valid_i  incoming signed score (M bits) and its valid
//   ready_o         packer can accept data_i this cycle
//   abort_i         synchronous discard of the current frame (wins over all)
//   ack_i           consumer has taken array_o (ignored while filling)
//   array_o         packed frame, element j at [j*N +: N], element 0 first
//   valid_o         array_o holds a complete frame
//   count_o         elements accepted into the current frame
//   sat_o           some element of the current frame was clamped
//
// Build option: define SCORE_PACKER_SAT_EN to clamp scores to the signed
// N-bit range (and report it on sat_o); otherwise the low N bits are packed
// unchanged and sat_o stays 0.

// One frame element: a write-enabled N-bit register.
module score_packer_elem #(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         we,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i)   q <= '0;
    else if (we) q <= d;
endmodule

module score_packer #(
  parameter int N  = 4,
  parameter int K  = 10,
  parameter int M  = 8,
  parameter int CW = $clog2(K+1)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [M-1:0]   data_i,
  input  logic           valid_i,
  output logic           ready_o,
  input  logic           abort_i,
  input  logic           ack_i,
  output logic [K*N-1:0] array_o,
  output logic           valid_o,
  output logic [CW-1:0]  count_o,
  output logic           sat_o
);
  typedef enum logic {FILL, FULL} state_t;

  state_t                state;
  logic                  accept;
  logic [N-1:0]          narrowed;
  logic                  clip;
  logic [K-1:0]          we;
  logic [K-1:0][N-1:0]   elems;

  assign ready_o = (state == FILL) && !rst_i;
  assign accept  = valid_i && ready_o && !abort_i;

`ifdef SCORE_PACKER_SAT_EN
  localparam logic signed [M-1:0] SMAX = M'(2**(N-1) - 1);
  localparam logic signed [M-1:0] SMIN = M'(-(2**(N-1)));
  logic signed [M-1:0] sdata;
  assign sdata = $signed(data_i);
  always_comb begin
    narrowed = data_i[N-1:0];
    clip     = 1'b0;
    if (sdata > SMAX) begin
      narrowed = SMAX[N-1:0];
      clip     = 1'b1;
    end else if (sdata < SMIN) begin
      narrowed = SMIN[N-1:0];
      clip     = 1'b1;
    end
  end
`else
  // Upper score bits are deliberately dropped: the value wraps.
  logic unused_data;
  assign unused_data = ^data_i;
  assign narrowed    = data_i[N-1:0];
  assign clip        = 1'b0;
`endif

  // Only the slot addressed by the running count is written on an accept.
  for (genvar j = 0; j < K; j++) begin : g_elem
    assign we[j] = accept && (count_o == CW'(j));
    score_packer_elem #(.N(N)) u_elem (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .we    (we[j]),
      .d     (narrowed),
      .q     (elems[j])
    );
  end

  assign array_o = elems;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= FILL;
      count_o <= '0;
      valid_o <= 1'b0;
      sat_o   <= 1'b0;
    end else if (abort_i) begin
      state   <= FILL;
      count_o <= '0;
      valid_o <= 1'b0;
      sat_o   <= 1'b0;
    end else begin
      case (state)
        FILL: if (accept) begin
          count_o <= count_o + CW'(1);
          if (clip) sat_o <= 1'b1;
          if (count_o == CW'(K-1)) begin
            state   <= FULL;
            valid_o <= 1'b1;
          end
        end
        FULL: if (ack_i) begin
          state   <= FILL;
          count_o <= '0;
          valid_o <= 1'b0;
          sat_o   <= 1'b0;
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_score_packer.sv
module tb_score_packer;
  localparam int N = 4, K = 10, M = 8, CW = $clog2(K+1);

  logic           clk = 1'b0, rst = 1'b1;
  logic [M-1:0]   data = '0;
  logic           valid = 1'b0, abort = 1'b0, ack = 1'b0;
  logic           ready, vld_o, sat;
  logic [K*N-1:0] arr;
  logic [CW-1:0]  cnt;

  always #5 clk = ~clk;

  score_packer #(.N(N), .K(K), .M(M)) dut (
    .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid), .ready_o(ready),
    .abort_i(abort), .ack_i(ack), .array_o(arr), .valid_o(vld_o),
    .count_o(cnt), .sat_o(sat)
  );

  int total = 0, bad = 0;

  // Reference model: frame contents as plain integers, count, full flag.
  int m_el[K];
  int m_cnt;
  bit m_full, m_sat;

  function automatic int sval(logic [M-1:0] d);
    return int'($signed(d));
  endfunction

  function automatic int narrow(logic [M-1:0] d);
    int v = sval(d);
`ifdef SCORE_PACKER_SAT_EN
    if (v > 2**(N-1) - 1) v = 2**(N-1) - 1;
    else if (v < -(2**(N-1))) v = -(2**(N-1));
`endif
    return ((v % 2**N) + 2**N) % 2**N;
  endfunction

  function automatic bit clips(logic [M-1:0] d);
`ifdef SCORE_PACKER_SAT_EN
    return sval(d) > 2**(N-1) - 1 || sval(d) < -(2**(N-1));
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    for (int j = 0; j < K; j++) m_el[j] = 0;
    m_cnt = 0; m_full = 0; m_sat = 0;
  endtask

  task automatic model_edge();
    if (abort) begin
      m_full = 0; m_cnt = 0; m_sat = 0;
    end else if (m_full) begin
      if (ack) begin m_full = 0; m_cnt = 0; m_sat = 0; end
    end else if (valid) begin
      m_el[m_cnt] = narrow(data);
      if (clips(data)) m_sat = 1;
      m_cnt++;
      if (m_cnt == K) m_full = 1;
    end
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all(string tag);
    logic [K*N-1:0] e;
    e = '0;
    for (int j = 0; j < K; j++) e[j*N +: N] = N'(m_el[j]);
    chk({tag, ".array"}, 64'(arr), 64'(e));
    chk({tag, ".count"}, 64'(cnt), 64'(m_cnt));
    chk({tag, ".valid"}, 64'(vld_o), 64'(m_full));
    chk({tag, ".ready"}, 64'(ready), 64'(!m_full && !rst));
    chk({tag, ".sat"},   64'(sat), 64'(m_sat));
  endtask

  // One clock: model follows the edge, outputs checked 1ns later,
  // returns at the following falling edge ready for new inputs.
  task automatic cyc(string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic drive(bit v, logic [M-1:0] d, bit a, bit ab);
    valid = v; data = d; ack = a; abort = ab;
  endtask

  typedef struct {
    bit          v;
    logic [M-1:0] d;
    bit          a;
    int          exp_cnt;
    bit          exp_vld;
    bit          exp_rdy;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [K*N-1:0] ramp;
    int rises;
    bit prev;
    logic [N-1:0] e0, e1;
    bit es;

    // Fill frame 0..9, ack, then one idle cycle.
    for (int i = 0; i < K; i++)
      tbl[i] = '{v:1'b1, d:M'(i), a:1'b0, exp_cnt:i+1, exp_vld:(i == K-1), exp_rdy:(i != K-1)};
    tbl[10] = '{v:1'b0, d:'0, a:1'b1, exp_cnt:0, exp_vld:1'b0, exp_rdy:1'b1};
    tbl[11] = '{v:1'b0, d:'0, a:1'b1, exp_cnt:0, exp_vld:1'b0, exp_rdy:1'b1};
    ramp = 40'h9876543210;

    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all("release");
    @(negedge clk);

    // Table-driven first frame.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].a, 1'b0);
      cyc("tbl");
      chk($sformatf("tbl%0d.count", i), 64'(cnt), 64'(tbl[i].exp_cnt));
      chk($sformatf("tbl%0d.valid", i), 64'(vld_o), 64'(tbl[i].exp_vld));
      chk($sformatf("tbl%0d.ready", i), 64'(ready), 64'(tbl[i].exp_rdy));
      if (i == K-1) chk("tbl.ramp", 64'(arr), 64'(ramp));
    end

    // Back-to-back frames: valid held high, ack echoes valid_o.
    rises = 0; prev = 0;
    data = 8'd3;
    for (int c = 0; c < 3*(K+1); c++) begin
      valid = 1'b1; ack = vld_o;
      cyc("b2b");
      if (vld_o && !prev) rises++;
      prev = vld_o;
      if (!vld_o) data = data + 8'd1;
    end
    chk("b2b.frames", 64'(rises), 64'd3);
    chk("b2b.end_count", 64'(cnt), 64'd0);

    // Abort with count 5 and valid high.
    for (int i = 0; i < 5; i++) begin drive(1, M'(i + 1), 0, 0); cyc("ab.fill"); end
    drive(1, 8'd9, 0, 1); cyc("ab.abort");
    chk("ab.count0", 64'(cnt), 64'd0);
    drive(1, 8'd6, 0, 0); cyc("ab.refill");
    chk("ab.elem0", 64'(arr[N-1:0]), 64'd6);
    for (int i = 0; i < K-1; i++) begin drive(1, M'(i), 0, 0); cyc("ab.fill2"); end
    chk("ab.full", 64'(vld_o), 64'd1);
    drive(0, '0, 0, 1); cyc("ab.full_abort");
    chk("ab.full_dropped", 64'(vld_o), 64'd0);

    // Narrowing: 100 and -128 followed by zeros.
    drive(1, 8'd100, 0, 0); cyc("sat");
    drive(1, 8'h80, 0, 0);  cyc("sat");
    for (int i = 0; i < K-2; i++) begin drive(1, 8'd0, 0, 0); cyc("sat"); end
`ifdef SCORE_PACKER_SAT_EN
    e0 = 4'h7; e1 = 4'h8; es = 1'b1;
`else
    e0 = 4'h4; e1 = 4'h0; es = 1'b0;
`endif
    chk("sat.e0", 64'(arr[N-1:0]), 64'(e0));
    chk("sat.e1", 64'(arr[2*N-1:N]), 64'(e1));
    chk("sat.flag", 64'(sat), 64'(es));
    drive(0, '0, 1, 0); cyc("sat.ack");
    chk("sat.cleared", 64'(sat), 64'd0);
    for (int i = 0; i < K; i++) begin drive(1, M'(i - 8), 0, 0); cyc("inrange"); end
    chk("inrange.sat", 64'(sat), 64'd0);
    drive(0, '0, 1, 0); cyc("inrange.ack");

    // Async reset at count 7, mid-cycle.
    for (int i = 0; i < 7; i++) begin drive(1, M'(i + 5), 0, 0); cyc("rst.fill"); end
    drive(0, '0, 0, 0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("rst.async");
    chk("rst.ready0", 64'(ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst.ready1", 64'(ready), 64'd1);
    @(negedge clk);

    // Random traffic: ack in FILL ignored, valid toggling, rare abort.
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 1)), M'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0));
      cyc("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/score_packer.md
# score_packer

Sequential frame assembler that sits upstream of the argmax stage: collects a stream of signed scores, one per accepted cycle, into a packed k×n-bit array and presents the complete frame to the argmax index stage. Holds the frame stable until the consumer acknowledges it, then refills. Element 0 is the first accepted score and occupies the least-significant n bits.

## Interface
- n, 4, width of each packed signed element
- k, 10, elements per frame (k ≥ 2)
- m, 8, width of each incoming signed score (m ≥ n)

- clk_i  input  1  clock, rising edge
- rst_i  input  1  reset, asynchronous, active-high
- data_i  input  m  signed score
- valid_i  input  1  data_i valid
- ready_o  output  1  packer can accept data_i this cycle
- abort_i  input  1  synchronous discard of current frame
- ack_i  input  1  consumer has taken array_o
- array_o  output  k*n  packed frame, element j at [j*n +: n]
- valid_o  output  1  array_o holds a complete frame
- count_o  output  $clog2(k+1)  elements accepted into current frame
- sat_o  output  1  at least one element of the presented frame was clamped

## Operation
- States: FILL, FULL. Reset state FILL.
- Reset values: array_o all zeros, count_o 0, valid_o 0, sat_o 0; ready_o 0 while rst_i high.
- ready_o = (state == FILL) && !rst_i, combinational from state. valid_o = (state == FULL), registered.
- FILL: on a cycle with valid_i && ready_o && !abort_i, narrowed(data_i) is written to element count_o; count_o increments. When the accept brings the count to k: go to FULL, count_o holds k.
- FULL: no accepts. ack_i high → FILL, count_o 0, sat_o 0. array_o keeps its old contents until overwritten element by element.
- ack_i in FILL: ignored.
- abort_i (either state): → FILL, count_o 0, sat_o 0, valid_o 0; any element offered in the same cycle is discarded. abort_i wins over ack_i and valid_i.
- Elements not yet rewritten in a partially filled frame are stale; consumers rely only on valid_o.
- Narrowing with SCORE_PACKER_SAT_EN defined: see Configuration. Without it: low n bits of data_i.

## Timing
- Accept at edge t → element visible on array_o and count_o after edge t.
- k-th accept at edge t → valid_o high, ready_o low after edge t. No accept can occur in the k-th accept's following cycle.
- ack_i sampled at edge t → valid_o low, ready_o high after edge t. First element of the next frame accepted at edge t+1 at earliest.
- Peak throughput: one frame per k+1 cycles.
- Asynchronous reset mid-frame or in FULL: all outputs take reset values immediately; the partial frame is lost.

## Configuration
- SCORE_PACKER_SAT_EN defined: each score is clamped to [-2^(n-1), 2^(n-1)-1] before packing. Any clamped accept sets sat_o (sticky until ack, abort or reset; visible from the cycle after that accept).
- Undefined: low n bits of data_i are packed unchanged (wraps); sat_o tied 0.

## Test plan
- Reset, then valid_i held high with data 0,1,...,9 (n=4, m=8, k=10) → valid_o high after the 10th accept edge, array_o = 0x9876543210, ready_o 0; ack_i one cycle → count_o 0, ready_o 1 next cycle.
- Back-to-back frames with valid_i held high continuously, ack_i pulsed the cycle valid_o rises → exactly one frame per 11 cycles, no element lost or duplicated.
- abort_i asserted with count_o = 5 and valid_i high → count_o 0, offered element dropped, next accepts start at element 0; abort in FULL → valid_o 0 without ack.
- SAT_EN defined: data 8'd100 and 8'h80 (-128) → elements 4'h7 and 4'h8, sat_o 1 once the frame is presented; frame of in-range values -8..7 → sat_o 0. SAT_EN undefined: 8'd100 → 4'h4, sat_o 0.
- Asynchronous rst_i pulsed mid-cycle at count_o = 7 → array_o 0, valid_o 0, count_o 0 immediately, ready_o 0 during reset, 1 after release.
- ack_i asserted in FILL and valid_i toggling randomly → ack ignored, only cycles with valid_i && ready_o advance count_o.
